rsa_exp_ctrl: RTL and testbench

Sequencer for modular exponentiation C = P^E mod M in the RSA top. It drives an external Montgomery multiplier (rsa_mmm) through a start/done handshake. Left-to-right square-and-multiply runs over all WIDTH exponent bits, with conversion into and out of the Montgomery domain. Sits between the SPI/register front end, which supplies operands and start, and the multiplier; it owns the running accumulator and the converted base.

---
 rtl/rsa_pkg.sv | 28 ++
 rtl/rsa_exp_ctrl.sv | 156 +++++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_pkg
// Description : Shared width default, sequencer state and phase encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    localparam int RSA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV_P = 3'd1,
        CONV_1 = 3'd2,
        SQUARE = 3'd3,
        MULT   = 3'd4,
        FINAL  = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Every multiplier operation splits into a launch cycle and a wait span.
    typedef enum logic {
        PH_ISSUE = 1'b0,
        PH_WAIT  = 1'b1
    } phase_t;

endpackage : rsa_pkg
`default_nettype wire

// File: rtl/rsa_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rsa_exp_ctrl
// Description : Left-to-right square-and-multiply sequencer driving an
//               external Montgomery multiplier through start/done.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] base_i,
    input  logic [WIDTH-1:0] exp_i,
    input  logic [WIDTH-1:0] r2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             mm_start_o,
    output logic [WIDTH-1:0] mm_a_o,
    output logic [WIDTH-1:0] mm_b_o,
    input  logic             mm_done_i,
    input  logic [WIDTH-1:0] mm_res_i
);

    localparam int               KW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0]    c_kmax = KW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    state_t            r_state;
    state_t            w_next_state;
    phase_t            r_phase;
    phase_t            w_next_phase;
    logic [KW-1:0]     r_k;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_pm;
    logic [WIDTH-1:0]  r_base;
    logic [WIDTH-1:0]  r_exp;
    logic [WIDTH-1:0]  r_r2;
    logic [WIDTH-1:0]  r_result;
    logic              w_in_op;
    logic              w_op_done;
    logic              w_last_bit;

    assign w_in_op    = (r_state != IDLE) && (r_state != DONE);
    assign w_op_done  = w_in_op && (r_phase == PH_WAIT) && mm_done_i;
    assign w_last_bit = (r_k == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= PH_ISSUE;
        end else begin
            r_state <= w_next_state;
            r_phase <= w_next_phase;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_phase = r_phase;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next_state = CONV_P;
                    w_next_phase = PH_ISSUE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
                w_next_phase = PH_ISSUE;
            end
            default: begin
                if (r_phase == PH_ISSUE) begin
                    w_next_phase = PH_WAIT;
                end else if (mm_done_i) begin
                    w_next_phase = PH_ISSUE;
                    case (r_state)
                        CONV_P:  w_next_state = CONV_1;
                        CONV_1:  w_next_state = SQUARE;
                        SQUARE: begin
                            if (r_exp[r_k])      w_next_state = MULT;
                            else if (w_last_bit) w_next_state = FINAL;
                            else                 w_next_state = SQUARE;
                        end
                        MULT:    w_next_state = w_last_bit ? FINAL : SQUARE;
                        FINAL:   w_next_state = DONE;
                        default: w_next_state = IDLE;
                    endcase
                end
            end
        endcase
    end

    // Operands are pure functions of state so they stay put across WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k      <= '0;
            r_acc    <= '0;
            r_pm     <= '0;
            r_base   <= '0;
            r_exp    <= '0;
            r_r2     <= '0;
            r_result <= '0;
        end else begin
            if ((r_state == IDLE) && start_i) begin
                r_base <= base_i;
                r_exp  <= exp_i;
                r_r2   <= r2_i;
                r_k    <= c_kmax;
            end
            if (w_op_done) begin
                case (r_state)
                    CONV_P: r_pm  <= mm_res_i;
                    CONV_1: r_acc <= mm_res_i;
                    SQUARE: begin
                        r_acc <= mm_res_i;
                        if (!r_exp[r_k] && !w_last_bit) r_k <= r_k - 1'b1;
                    end
                    MULT: begin
                        r_acc <= mm_res_i;
                        if (!w_last_bit) r_k <= r_k - 1'b1;
                    end
                    FINAL: begin
                        r_acc    <= mm_res_i;
                        r_result <= mm_res_i;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o     = (r_state != IDLE);
    assign done_o     = (r_state == DONE);
    assign mm_start_o = w_in_op && (r_phase == PH_ISSUE);
    assign result_o   = r_result;

    always_comb begin
        mm_a_o = '0;
        mm_b_o = '0;
        case (r_state)
            CONV_P: begin mm_a_o = r_base; mm_b_o = r_r2;  end
            CONV_1: begin mm_a_o = c_one;  mm_b_o = r_r2;  end
            SQUARE: begin mm_a_o = r_acc;  mm_b_o = r_acc; end
            MULT:   begin mm_a_o = r_acc;  mm_b_o = r_pm;  end
            FINAL:  begin mm_a_o = r_acc;  mm_b_o = c_one; end
            default: ;
        endcase
    end

endmodule : rsa_exp_ctrl
`default_nettype wire

// File: tb/tb_rsa_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_exp_ctrl
// Description : Scoreboard bench for rsa_exp_ctrl with a behavioural
//               Montgomery multiplier of configurable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_exp_ctrl;

    localparam int WIDTH = 8;
    localparam int MOD   = 187;
    localparam int R2    = 86;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [WIDTH-1:0] base_i;
    logic [WIDTH-1:0] exp_i;
    logic [WIDTH-1:0] r2_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             mm_start_o;
    logic [WIDTH-1:0] mm_a_o;
    logic [WIDTH-1:0] mm_b_o;
    logic             mm_done_i;
    logic [WIDTH-1:0] mm_res_i;

    rsa_exp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .base_i     (base_i),
        .exp_i      (exp_i),
        .r2_i       (r2_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .mm_start_o (mm_start_o),
        .mm_a_o     (mm_a_o),
        .mm_b_o     (mm_b_o),
        .mm_done_i  (mm_done_i),
        .mm_res_i   (mm_res_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 3;
    int spur_req = 0;
    int spur_seen = 0;

    typedef struct {
        int res;
        int done_edge;
        int n_ops;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int ref_modexp(input int p, input int e);
        int r = 1 % MOD;
        for (int i = 0; i < e; i++) r = (r * p) % MOD;
        return r;
    endfunction

    function automatic int popcnt(input int e);
        int c = 0;
        for (int i = 0; i < WIDTH; i++) c += (e >> i) & 1;
        return c;
    endfunction

    function automatic int rinv();
        for (int x = 1; x < MOD; x++) if (((x * 256) % MOD) == 1) return x;
        return 0;
    endfunction

    function automatic int mont(input int a, input int b);
        return (((a * b) % MOD) * rinv()) % MOD;
    endfunction

    // Behavioural multiplier: answers L cycles after each launch.
    int busy_cnt = 0;
    int cap_a = 0;
    int cap_b = 0;
    initial begin
        mm_done_i = 1'b0;
        mm_res_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            mm_done_i = 1'b0;
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        mm_done_i = 1'b1;
                        mm_res_i  = WIDTH'(mont(cap_a, cap_b));
                    end
                end
                if (mm_start_o) begin
                    busy_cnt = lat;
                    cap_a    = int'(mm_a_o);
                    cap_b    = int'(mm_b_o);
                end else if (busy_cnt == 0 && !mm_done_i && spur_req != spur_seen) begin
                    mm_done_i = 1'b1;
                    mm_res_i  = 8'h5A;
                    spur_seen = spur_req;
                end
            end
        end
    end

    // Monitor: operand stability, op count and done-cycle scoreboard.
    int   ops_seen = 0;
    logic prev_busy = 1'b0;
    logic waiting = 1'b0;
    int   hold_ab = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                waiting   = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (busy_o && !prev_busy) ops_seen = 0;
                prev_busy = busy_o;
                if (mm_start_o) begin
                    ops_seen++;
                    hold_ab = int'({mm_a_o, mm_b_o});
                    waiting = 1'b1;
                end else if (waiting) begin
                    check("operand_stable", int'({mm_a_o, mm_b_o}), hold_ab);
                    if (mm_done_i) waiting = 1'b0;
                end
                if (done_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", int'(result_o), e.res);
                        check("done_cycle", cyc, e.done_edge);
                        check("op_count", ops_seen, e.n_ops);
                        check("busy_at_done", int'(busy_o), 1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int p, input int e, input int l, output int done_edge);
        int t0;
        int n;
        lat     = l;
        base_i  = WIDTH'(p);
        exp_i   = WIDTH'(e);
        r2_i    = WIDTH'(R2);
        start_i = 1'b1;
        tick();
        t0      = cyc;
        start_i = 1'b0;
        n       = 3 + WIDTH + popcnt(e);
        done_edge = t0 + n * (l + 1);
        exp_q.push_back('{ref_modexp(p, e), done_edge, n});
        check("busy_after_start", int'(busy_o), 1);
    endtask

    task automatic poke_start();
        repeat (5) tick();
        base_i  = 8'hFF;
        exp_i   = 8'h00;
        r2_i    = 8'h00;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            tick();
            guard++;
        end
        if (guard >= 3000) begin
            check("done_timeout", 1, 0);
            exp_q.delete();
        end
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     int'(busy_o),     0);
        check({tag, "_done"},     int'(done_o),     0);
        check({tag, "_mm_start"}, int'(mm_start_o), 0);
        check({tag, "_result"},   int'(result_o),   0);
        check({tag, "_mm_a"},     int'(mm_a_o),     0);
        check({tag, "_mm_b"},     int'(mm_b_o),     0);
    endtask

    initial begin
        int d;
        int p;
        int e;
        int last_res;
        rst     = 1'b1;
        start_i = 1'b0;
        base_i  = '0;
        exp_i   = '0;
        r2_i    = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        issue(88, 7, 3, d);
        wait_done();
        last_res = ref_modexp(88, 7);

        // Stray completion while idle must leave everything untouched.
        spur_req++;
        repeat (3) tick();
        check("spur_busy",     int'(busy_o),     0);
        check("spur_mm_start", int'(mm_start_o), 0);
        check("spur_result",   int'(result_o),   last_res);

        issue(11, 23, 3, d);
        poke_start();
        wait_done();
        check("held_result", int'(result_o), 88);

        issue(88, 0, 2, d);
        wait_done();
        issue(2, 255, 1, d);
        wait_done();

        // Start raised during the done cycle is dropped; one cycle later it is taken.
        issue(88, 7, 1, d);
        while (cyc < d && cyc < d + 10) tick();
        base_i  = 8'h33;
        exp_i   = 8'h44;
        start_i = 1'b1;
        tick();
        check("start_in_done_ignored", int'(busy_o), 0);
        issue(11, 23, 2, d);
        wait_done();

        for (int i = 0; i < 8; i++) begin
            p = int'($urandom_range(0, MOD - 1));
            e = int'($urandom_range(0, 255));
            issue(p, e, int'($urandom_range(1, 4)), d);
            wait_done();
        end

        issue(88, 7, 3, d);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        check_all_zero("midrun_reset");
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("after_reset_done", int'(done_o), 0);
        issue(11, 23, 3, d);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rsa_exp_ctrl
`default_nettype wire
